mux_scan: RTL and testbench

MUX_SCAN -- requirements
Module: mux_scan

---
 rtl/mux_scan_if.sv | 21 ++
 rtl/mux_scan.sv | 119 +++++++++++
 tb/tb_mux_scan.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_if.sv
// Channel-select bus for mux_scan: control and channel data in, registered selection out.
interface mux_scan_if #(
    parameter int NR_CH = 4,
    parameter int DW    = 2
);
    localparam int SW = (NR_CH > 1) ? $clog2(NR_CH) : 1;

    logic                   mode;
    logic [SW-1:0]          sel;
    logic                   freeze;
    logic [NR_CH*DW-1:0]    data_in;
    logic [DW-1:0]          out;
    logic [SW-1:0]          out_ch;
    logic                   out_valid;
    logic                   wrap;

    modport master (output mode, sel, freeze, data_in,
                    input  out, out_ch, out_valid, wrap);
    modport slave  (input  mode, sel, freeze, data_in,
                    output out, out_ch, out_valid, wrap);
endinterface

// File: rtl/mux_scan.sv
// Channel mux with manual select and auto-scan; every channel is shown for HOLD
// unfrozen cycles in scan mode, and all outputs are registered.
module mux_scan #(
    parameter int NR_CH = 4,
    parameter int DW    = 2,
    parameter int HOLD  = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    mux_scan_if.slave bus
);
    localparam int SW = (NR_CH > 1) ? $clog2(NR_CH) : 1;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int NP = 1 << SW;
    localparam logic [SW-1:0] LAST_CH   = SW'(NR_CH - 1);
    localparam logic [HW-1:0] LAST_HOLD = HW'(HOLD - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAN  = 2'd1;
    localparam logic [1:0] S_SCAN = 2'd2;

    // Channel table padded to a power of two; unused slots read as zero so an
    // out-of-range manual select naturally yields out=0.
    logic [NP-1:0][DW-1:0] ch;

    logic [1:0]    state;
    logic [SW-1:0] idx;
    logic [HW-1:0] cnt;
    logic          swept;
    logic [DW-1:0] out_q;
    logic [SW-1:0] ch_q;
    logic          vld_q;
    logic          wrap_q;
    logic [DW-1:0] man_out;
    logic          man_vld;
    logic          hold_done;

    generate
        for (genvar i = 0; i < NP; i++) begin : g_ch
            if (i < NR_CH) begin : g_live
                assign ch[i] = bus.data_in[i*DW +: DW];
            end else begin : g_pad
                assign ch[i] = '0;
            end
        end
    endgenerate

    always_comb begin
        man_out   = ch[bus.sel];
        man_vld   = (bus.sel <= LAST_CH);
        hold_done = (cnt == LAST_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            idx    <= '0;
            cnt    <= '0;
            swept  <= 1'b0;
            out_q  <= '0;
            ch_q   <= '0;
            vld_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else if (bus.freeze) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    state <= bus.mode ? S_SCAN : S_MAN;
                    idx   <= '0;
                    cnt   <= '0;
                    swept <= 1'b0;
                end
                S_MAN: begin
                    if (bus.mode) begin
                        state <= S_SCAN;
                        idx   <= '0;
                        cnt   <= '0;
                        swept <= 1'b0;
                    end else begin
                        out_q <= man_out;
                        ch_q  <= bus.sel;
                        vld_q <= man_vld;
                    end
                end
                S_SCAN: begin
                    if (!bus.mode) begin
                        // Leaving scan discards any pending hold expiry.
                        state <= S_MAN;
                        swept <= 1'b0;
                        out_q <= man_out;
                        ch_q  <= bus.sel;
                        vld_q <= man_vld;
                    end else begin
                        out_q  <= ch[idx];
                        ch_q   <= idx;
                        vld_q  <= 1'b1;
                        // wrap lines up with the cycle out_ch shows channel 0 again.
                        wrap_q <= swept;
                        swept  <= hold_done && (idx == LAST_CH);
                        if (hold_done) begin
                            cnt <= '0;
                            idx <= (idx == LAST_CH) ? '0 : idx + SW'(1);
                        end else begin
                            cnt <= cnt + HW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.out       = out_q;
    assign bus.out_ch    = ch_q;
    assign bus.out_valid = vld_q;
    assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_mux_scan.sv
// Bench for mux_scan: three parameter sets against a sweep-count model, plus literal pins.
module tb_mux_scan;
    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       run = 1'b0;
    logic       mode;
    logic       freeze;
    logic [1:0] sel;
    logic [1:0] dv [4];
    int         vec_cnt = 0;
    int         err_cnt = 0;

    always #5 clk = ~clk;

    mux_scan_if #(.NR_CH(4), .DW(2)) bus_a ();
    mux_scan_if #(.NR_CH(3), .DW(2)) bus_b ();
    mux_scan_if #(.NR_CH(2), .DW(2)) bus_c ();

    assign bus_a.mode = mode;  assign bus_a.freeze = freeze;  assign bus_a.sel = sel;
    assign bus_b.mode = mode;  assign bus_b.freeze = freeze;  assign bus_b.sel = sel;
    assign bus_c.mode = mode;  assign bus_c.freeze = freeze;  assign bus_c.sel = sel[0];
    assign bus_a.data_in = {dv[3], dv[2], dv[1], dv[0]};
    assign bus_b.data_in = {dv[2], dv[1], dv[0]};
    assign bus_c.data_in = {dv[1], dv[0]};

    mux_scan #(.NR_CH(4), .DW(2), .HOLD(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    mux_scan #(.NR_CH(3), .DW(2), .HOLD(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    mux_scan #(.NR_CH(2), .DW(2), .HOLD(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    logic [1:0] d_out [NI];
    logic [1:0] d_ch  [NI];
    logic       d_vld [NI];
    logic       d_wrap[NI];
    assign d_out[0] = bus_a.out;  assign d_ch[0] = bus_a.out_ch;
    assign d_out[1] = bus_b.out;  assign d_ch[1] = bus_b.out_ch;
    assign d_out[2] = bus_c.out;  assign d_ch[2] = {1'b0, bus_c.out_ch};
    assign d_vld[0] = bus_a.out_valid;  assign d_wrap[0] = bus_a.wrap;
    assign d_vld[1] = bus_b.out_valid;  assign d_wrap[1] = bus_b.wrap;
    assign d_vld[2] = bus_c.out_valid;  assign d_wrap[2] = bus_c.wrap;

    function automatic int nch(input int k);
        return (k == 0) ? 4 : (k == 1) ? 3 : 2;
    endfunction
    function automatic int hld(input int k);
        return (k == 0) ? 4 : (k == 1) ? 2 : 1;
    endfunction
    function automatic int sel_of(input int k, input logic [1:0] s);
        return (k == 2) ? int'(s[0]) : int'(s);
    endfunction

    // Model: mode 0=idle 1=manual 2=scan; pos counts scan presentations since entry.
    int         m_st  [NI];
    int         m_pos [NI];
    logic [1:0] m_out [NI];
    logic [1:0] m_ch  [NI];
    logic       m_vld [NI];
    logic       m_wrap[NI];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NI; k++) begin
                m_st[k] <= 0;  m_pos[k] <= 0;  m_out[k] <= 2'd0;
                m_ch[k] <= 2'd0;  m_vld[k] <= 1'b0;  m_wrap[k] <= 1'b0;
            end
        end else if (freeze) begin
            for (int k = 0; k < NI; k++) m_wrap[k] <= 1'b0;
        end else begin
            for (int k = 0; k < NI; k++) begin
                m_wrap[k] <= 1'b0;
                if (m_st[k] == 0) begin
                    m_st[k]  <= mode ? 2 : 1;
                    m_pos[k] <= 0;
                end else if (m_st[k] == 1 && mode) begin
                    m_st[k]  <= 2;
                    m_pos[k] <= 0;
                end else if (!mode) begin
                    m_st[k]  <= 1;
                    m_ch[k]  <= 2'(sel_of(k, sel));
                    m_vld[k] <= sel_of(k, sel) < nch(k);
                    m_out[k] <= (sel_of(k, sel) < nch(k)) ? dv[sel_of(k, sel)] : 2'd0;
                end else begin
                    m_ch[k]   <= 2'((m_pos[k] / hld(k)) % nch(k));
                    m_out[k]  <= dv[(m_pos[k] / hld(k)) % nch(k)];
                    m_vld[k]  <= 1'b1;
                    m_wrap[k] <= (m_pos[k] > 0) && (m_pos[k] % (hld(k) * nch(k)) == 0);
                    m_pos[k]  <= m_pos[k] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            for (int k = 0; k < NI; k++) begin
                vec_cnt++;
                if ({d_out[k], d_ch[k], d_vld[k], d_wrap[k]} !== {m_out[k], m_ch[k], m_vld[k], m_wrap[k]}) begin
                    err_cnt++;
                    $display("FAIL model inst%0d t=%0t out=%0d want %0d ch=%0d want %0d vld=%0b want %0b wrap=%0b want %0b",
                             k, $time, d_out[k], m_out[k], d_ch[k], m_ch[k], d_vld[k], m_vld[k], d_wrap[k], m_wrap[k]);
                end
            end
        end
    end

    task automatic pin(input string nm, input int act, input int exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n;
        mode = 1'b0;  freeze = 1'b0;  sel = 2'd2;
        for (int i = 0; i < 4; i++) dv[i] = 2'(i);
        #1 rst_n = 1'b0;
        run = 1'b1;
        tick(2);
        pin("rst_out",  bus_a.out, 0);
        pin("rst_vld",  bus_a.out_valid, 0);
        pin("rst_wrap", bus_a.wrap, 0);
        rst_n = 1'b1;

        // Manual select
        tick(1);  pin("idle_exit_vld", bus_a.out_valid, 0);
        tick(1);  pin("man_out", bus_a.out, 2);  pin("man_ch", bus_a.out_ch, 2);
        pin("man_vld", bus_a.out_valid, 1);
        sel = 2'd1;  tick(1);  pin("man_sel1", bus_a.out, 1);
        sel = 2'd3;  tick(1);
        pin("b_bad_vld", bus_b.out_valid, 0);  pin("b_bad_out", bus_b.out, 0);
        pin("b_bad_ch", bus_b.out_ch, 3);
        sel = 2'd1;  tick(1);
        pin("b_good_vld", bus_b.out_valid, 1);  pin("b_good_out", bus_b.out, 1);
        for (int i = 0; i < 8; i++) begin
            sel = 2'(i);
            dv[i % 4] = 2'(i + 1);
            tick(1);
        end
        for (int i = 0; i < 4; i++) dv[i] = 2'(i);

        // Scan: entry edge leaves out alone, then 4 cycles per channel
        mode = 1'b1;  tick(1);  pin("scan_entry_hold", bus_a.out_ch, 3);
        for (int i = 0; i < 17; i++) begin
            tick(1);
            pin("scan_ch", bus_a.out_ch, (i < 16) ? i / 4 : 0);
            pin("scan_wrap", bus_a.wrap, (i == 16) ? 1 : 0);
        end
        tick(1);
        freeze = 1'b1;  tick(3);  pin("frz_ch", bus_a.out_ch, 0);  pin("frz_wrap", bus_a.wrap, 0);
        freeze = 1'b0;
        tick(1);  pin("frz_rem1", bus_a.out_ch, 0);
        tick(1);  pin("frz_rem2", bus_a.out_ch, 0);
        tick(1);  pin("frz_next", bus_a.out_ch, 1);
        freeze = 1'b1;  mode = 1'b0;  tick(1);
        pin("frz_mode_ch", bus_a.out_ch, 1);  pin("frz_mode_vld", bus_a.out_valid, 1);
        freeze = 1'b0;  mode = 1'b1;  tick(2);
        // Hold counter now at its last value; mode change wins
        mode = 1'b0;  sel = 2'd2;  tick(1);
        pin("race_ch", bus_a.out_ch, 2);  pin("race_out", bus_a.out, 2);

        // HOLD=1, NR_CH=2 alternation
        mode = 1'b1;  tick(1);
        for (int i = 0; i < 6; i++) begin
            tick(1);
            pin("c_ch", bus_c.out_ch, i % 2);
            pin("c_wrap", bus_c.wrap, (i >= 2 && i % 2 == 0) ? 1 : 0);
        end

        // Async reset mid-scan
        n = 0;
        while (bus_a.out_ch != 2'd2 && n < 20) begin tick(1); n++; end
        pin("find_ch2", bus_a.out_ch, 2);
        #2 rst_n = 1'b0;
        #1;
        pin("arst_out", bus_a.out, 0);  pin("arst_ch", bus_a.out_ch, 0);
        pin("arst_vld", bus_a.out_valid, 0);  pin("arst_wrap", bus_a.wrap, 0);
        tick(1);
        rst_n = 1'b1;
        tick(1);  pin("rel_idle_vld", bus_a.out_valid, 0);  pin("rel_wrap", bus_a.wrap, 0);
        tick(1);  pin("rel_ch", bus_a.out_ch, 0);  pin("rel_vld", bus_a.out_valid, 1);

        // Mixed traffic, model-checked only
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            freeze = ($urandom_range(0, 7) == 0);
            sel = 2'($urandom);
            for (int j = 0; j < 4; j++) dv[j] = 2'($urandom);
            tick(1);
        end
        tick(1);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
